// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register in-flight write counters for the scalar and vector files.
// Latency: stall/issue are combinational from registered counts; pending bits move one edge after issue/WB.
// Backpressure: stall holds decode on RAW hazards, on a saturated destination counter, or while draining.
module reg_scoreboard #(
   parameter int NREG           = 32,
   parameter int CNT_W          = 2,
   parameter bit ZERO_HARDWIRED = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [$clog2(NREG)-1:0]  id_rs1,
   input  logic [$clog2(NREG)-1:0]  id_rs2,
   input  logic [$clog2(NREG)-1:0]  id_rd,
   input  logic                     id_use_rs1,
   input  logic                     id_use_rs2,
   input  logic                     id_src_vec,
   input  logic                     id_wr_scalar,
   input  logic                     id_wr_vec,
   input  logic                     wb_we,
   input  logic                     wb_we_vec,
   input  logic [$clog2(NREG)-1:0]  wb_rd,
   input  logic                     flush_req,
   output logic                     stall,
   output logic                     issue,
   output logic [NREG-1:0]          pending_s,
   output logic [NREG-1:0]          pending_v,
   output logic                     drained,
   output logic                     sb_err
);

   localparam int IW = $clog2(NREG);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt_s [NREG];
   logic [CNT_W-1:0] cnt_v [NREG];

   logic all_clear;
   logic rs1_pend, rs2_pend;
   logic rd_full_s, rd_full_v;
   logic hazard;
   logic wb_s_tracked;
   logic err_s, err_v;

   // Per-register "has writes in flight" view; scalar r0 is reported idle when hardwired.
   always_comb begin
      pending_s = '0;
      pending_v = '0;
      for (int r = 0; r < NREG; r++) begin
         pending_s[r] = (cnt_s[r] != '0) && !(ZERO_HARDWIRED && r == 0);
         pending_v[r] = (cnt_v[r] != '0);
      end
   end

   // Hazard detection against registered counts only (no WB bypass).
   always_comb begin
      all_clear = ~|pending_s & ~|pending_v;
      rs1_pend  = id_src_vec ? pending_v[id_rs1] : pending_s[id_rs1];
      rs2_pend  = id_src_vec ? pending_v[id_rs2] : pending_s[id_rs2];
      rd_full_s = (cnt_s[id_rd] == CNT_MAX);
      rd_full_v = (cnt_v[id_rd] == CNT_MAX);
      hazard    = id_valid & ((id_use_rs1 & rs1_pend) |
                              (id_use_rs2 & rs2_pend) |
                              (id_wr_scalar & rd_full_s) |
                              (id_wr_vec & rd_full_v));
      stall     = ((state == DRAIN) & id_valid) | hazard;
      issue     = id_valid & ~stall;
   end

   // A WB to an idle counter is a protocol error; writes to a hardwired r0 are not tracked at all.
   always_comb begin
      wb_s_tracked = !(ZERO_HARDWIRED && wb_rd == '0);
      err_s        = wb_we & wb_s_tracked & (cnt_s[wb_rd] == '0);
      err_v        = wb_we_vec & (cnt_v[wb_rd] == '0);
   end

   // Counter update: +1 on issue to rd, -1 on WB with a nonzero count; both together cancel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_s[r] <= '0;
            cnt_v[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            logic inc_s, dec_s, inc_v, dec_v;
            inc_s = issue & id_wr_scalar & (id_rd == IW'(r)) & !(ZERO_HARDWIRED && r == 0);
            dec_s = wb_we & (wb_rd == IW'(r)) & (cnt_s[r] != '0);
            inc_v = issue & id_wr_vec & (id_rd == IW'(r));
            dec_v = wb_we_vec & (wb_rd == IW'(r)) & (cnt_v[r] != '0);
            if (inc_s && !dec_s)
               cnt_s[r] <= cnt_s[r] + 1'b1;
            else if (dec_s && !inc_s)
               cnt_s[r] <= cnt_s[r] - 1'b1;
            if (inc_v && !dec_v)
               cnt_v[r] <= cnt_v[r] + 1'b1;
            else if (dec_v && !inc_v)
               cnt_v[r] <= cnt_v[r] - 1'b1;
         end
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sb_err <= 1'b0;
      else if (err_s | err_v)
         sb_err <= 1'b1;
   end

   // Drain FSM: leave DRAIN once the pre-update counts are all zero; drained pulses for one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         drained <= 1'b0;
      end else begin
         drained <= 1'b0;
         case (state)
            IDLE: if (flush_req) state <= DRAIN;
            DRAIN: begin
               if (all_clear) begin
                  state   <= IDLE;
                  drained <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomised and directed stimulus for reg_scoreboard checked against a counter-array model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The model advances on each rising edge from the same inputs the DUT sees.
module tb_reg_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs1, id_use_rs2, id_src_vec, id_wr_scalar, id_wr_vec;
   logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
   logic       wb_we, wb_we_vec, flush_req;
   logic       stall, issue, drained, sb_err;
   logic [31:0] pending_s, pending_v;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: plain integer counters, a drain flag and the expected registered outputs.
   int cs [32];
   int cv [32];
   bit m_drain, m_drained, m_err;

   reg_scoreboard #(.NREG(32), .CNT_W(2), .ZERO_HARDWIRED(1'b1)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_src_vec(id_src_vec),
      .id_wr_scalar(id_wr_scalar), .id_wr_vec(id_wr_vec),
      .wb_we(wb_we), .wb_we_vec(wb_we_vec), .wb_rd(wb_rd), .flush_req(flush_req),
      .stall(stall), .issue(issue), .pending_s(pending_s), .pending_v(pending_v),
      .drained(drained), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         cs[i] = 0;
         cv[i] = 0;
      end
      m_drain = 0;
      m_drained = 0;
      m_err = 0;
   endtask

   task automatic idle_in();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; id_src_vec = 0;
      id_wr_scalar = 0; id_wr_vec = 0;
      wb_we = 0; wb_we_vec = 0; wb_rd = 0; flush_req = 0;
   endtask

   function automatic bit m_pend(int x, bit vec);
      if (vec) return cv[x] > 0;
      return (x != 0) && (cs[x] > 0);
   endfunction

   function automatic bit m_stall();
      bit hz;
      hz = id_valid && ((id_use_rs1 && m_pend(id_rs1, id_src_vec)) ||
                        (id_use_rs2 && m_pend(id_rs2, id_src_vec)) ||
                        (id_wr_scalar && cs[id_rd] == 3) ||
                        (id_wr_vec && cv[id_rd] == 3));
      return (m_drain && id_valid) || hz;
   endfunction

   function automatic logic [31:0] m_pvec(bit vec);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 32; i++) v[i] = m_pend(i, vec);
      return v;
   endfunction

   task automatic check_all(input string tag);
      bit es;
      es = m_stall();
      check({tag, ".stall"}, stall, es);
      check({tag, ".issue"}, issue, id_valid && !es);
      check({tag, ".pending_s"}, pending_s, m_pvec(0));
      check({tag, ".pending_v"}, pending_v, m_pvec(1));
      check({tag, ".drained"}, drained, m_drained);
      check({tag, ".sb_err"}, sb_err, m_err);
   endtask

   // One clock: check outputs for the current inputs, then advance the model across the rising edge.
   task automatic step(input string tag);
      int  ns [32];
      int  nv [32];
      bit  all0, iss;
      #1;
      check_all(tag);
      ns = cs;
      nv = cv;
      all0 = 1;
      for (int i = 0; i < 32; i++) if (cs[i] != 0 || cv[i] != 0) all0 = 0;
      iss = id_valid && !m_stall();
      if (iss && id_wr_scalar && id_rd != 0) ns[id_rd]++;
      if (iss && id_wr_vec) nv[id_rd]++;
      if (wb_we && wb_rd != 0) begin
         if (cs[wb_rd] > 0) ns[wb_rd]--; else m_err = 1;
      end
      if (wb_we_vec) begin
         if (cv[wb_rd] > 0) nv[wb_rd]--; else m_err = 1;
      end
      @(posedge clk);
      cs = ns;
      cv = nv;
      m_drained = 0;
      if (m_drain) begin
         if (all0) begin
            m_drain = 0;
            m_drained = 1;
         end
      end else if (flush_req) begin
         m_drain = 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1;
   endtask

   task automatic rand_phase(input int n, input bit allow_err);
      int r;
      for (int c = 0; c < n; c++) begin
         id_valid     = ($urandom % 4) != 0;
         id_rs1       = 5'($urandom_range(0, 7));
         id_rs2       = 5'($urandom_range(0, 7));
         id_rd        = 5'($urandom_range(0, 7));
         id_use_rs1   = $urandom % 2;
         id_use_rs2   = $urandom % 2;
         id_src_vec   = $urandom % 2;
         id_wr_scalar = $urandom % 2;
         id_wr_vec    = ($urandom % 3) == 0;
         flush_req    = ($urandom % 40) == 0;
         r            = $urandom_range(0, 7);
         wb_rd        = 5'(r);
         wb_we        = (r != 0) && ($urandom % 2) && (allow_err ? ($urandom % 4 != 0) || cs[r] > 0 : cs[r] > 0);
         wb_we_vec    = ($urandom % 2) && (allow_err ? ($urandom % 4 != 0) || cv[r] > 0 : cv[r] > 0);
         step("rand");
      end
   endtask

   initial begin
      idle_in();
      model_reset();
      rst = 0;
      @(negedge clk);
      id_valid = 1;
      do_reset();
      check("rst_issue_eq_valid", issue, 1'b1);

      // RAW on scalar r3 released the cycle after its WB.
      idle_in();
      id_valid = 1; id_wr_scalar = 1; id_rd = 3;
      step("t2_issue");
      idle_in();
      id_valid = 1; id_use_rs1 = 1; id_rs1 = 3;
      #1; check("t2_raw_stall", stall, 1'b1); check("t2_pend3", pending_s[3], 1'b1);
      step("t2_read");
      wb_we = 1; wb_rd = 3;
      step("t2_wb");
      wb_we = 0;
      #1; check("t2_release", issue, 1'b1); check("t2_pend3_clr", pending_s[3], 1'b0);
      step("t2_go");

      // Vector counter saturation on v5.
      idle_in();
      id_valid = 1; id_wr_vec = 1; id_rd = 5;
      repeat (3) step("t3_fill");
      #1; check("t3_full_stall", stall, 1'b1);
      step("t3_full");
      idle_in();
      wb_we_vec = 1; wb_rd = 5;
      repeat (3) step("t3_wb");
      idle_in();
      #1; check("t3_pendv5_clr", pending_v[5], 1'b0);
      step("t3_done");

      // Scalar r0 is never tracked.
      id_valid = 1; id_wr_scalar = 1; id_rd = 0;
      step("t4_wr0");
      idle_in();
      id_valid = 1; id_use_rs1 = 1; id_rs1 = 0;
      #1; check("t4_r0_nostall", stall, 1'b0); check("t4_pend0", pending_s[0], 1'b0);
      step("t4_rd0");

      // Simultaneous issue and WB on r7, then a WB to an idle register.
      idle_in();
      id_valid = 1; id_wr_scalar = 1; id_rd = 7;
      step("t5_prime");
      wb_we = 1; wb_rd = 7;
      step("t5_both");
      idle_in();
      #1; check("t5_pend7_kept", pending_s[7], 1'b1);
      wb_we = 1; wb_rd = 7;
      step("t5_clr7");
      wb_rd = 9;
      step("t5_err");
      idle_in();
      #1; check("t5_err_set", sb_err, 1'b1);
      repeat (2) step("t5_sticky");

      // Reset in the middle of a drain with two writes outstanding.
      do_reset();
      id_valid = 1; id_wr_scalar = 1; id_wr_vec = 1; id_rd = 2;
      step("t1_issue");
      idle_in();
      flush_req = 1;
      step("t1_flush");
      flush_req = 0; id_valid = 1;
      step("t1_drain");
      do_reset();
      check("t1_rst_pend_s", pending_s, 32'h0);
      check("t1_rst_pend_v", pending_v, 32'h0);

      // Drain with outstanding r2 and v4.
      idle_in();
      id_valid = 1; id_wr_scalar = 1; id_rd = 2;
      step("t6_r2");
      id_wr_scalar = 0; id_wr_vec = 1; id_rd = 4;
      step("t6_v4");
      idle_in();
      flush_req = 1;
      step("t6_flush");
      flush_req = 0; id_valid = 1;
      #1; check("t6_drain_stall", stall, 1'b1);
      wb_we = 1; wb_rd = 2;
      step("t6_wb2");
      wb_we = 0; wb_we_vec = 1; wb_rd = 4;
      step("t6_wb4");
      wb_we_vec = 0; flush_req = 1;
      step("t6_exit");
      flush_req = 0;
      #1; check("t6_drained", drained, 1'b1); check("t6_no_stall", stall, 1'b0);
      step("t6_pulse");
      #1; check("t6_pulse_once", drained, 1'b0);
      step("t6_after");

      // Flush with nothing outstanding.
      idle_in();
      flush_req = 1;
      step("t7_flush");
      flush_req = 0;
      step("t7_drain");
      #1; check("t7_drained", drained, 1'b1);
      step("t7_idle");

      // Random traffic, error-free then with stray WBs.
      rand_phase(800, 0);
      rand_phase(300, 1);

      idle_in();
      step("final");
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
